// File: rtl/timer_pkg.sv
// Shared types and digit limits for the irrigation countdown timer.
package timer_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam int unsigned TSEC_MAX_C  = 5;
    localparam int unsigned MIN_U_MAX_C = 9;
    localparam int unsigned MIN_T_MAX_C = 5;

endpackage : timer_pkg

// File: rtl/sec_tens_min_counter_if.sv
// Bus between the units-of-seconds stage, the duration selector and this stage.
interface sec_tens_min_counter_if;
    import timer_pkg::*;

    logic borrow_in;
    logic units_zero;
    logic pause;
    logic load;
    bcd_t preset_tsec;
    bcd_t preset_min_u;
    bcd_t preset_min_t;
    bcd_t tsec;
    bcd_t min_u;
    bcd_t min_t;
    logic reach_zero;
    logic expired;

    modport master (
        output borrow_in, units_zero, pause, load,
        output preset_tsec, preset_min_u, preset_min_t,
        input  tsec, min_u, min_t, reach_zero, expired
    );

    modport slave (
        input  borrow_in, units_zero, pause, load,
        input  preset_tsec, preset_min_u, preset_min_t,
        output tsec, min_u, min_t, reach_zero, expired
    );

endinterface : sec_tens_min_counter_if

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with clamped preset and borrow chaining.
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter int unsigned MAX = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  bcd_t load_val,
    input  logic dec_in,
    input  logic block,
    output bcd_t digit,
    output logic borrow_out,
    output logic is_zero
);

    localparam bcd_t MAX_V = bcd_t'(MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (load) begin
            digit <= (load_val > MAX_V) ? MAX_V : load_val;
        end else if (dec_in && !block) begin
            digit <= is_zero ? MAX_V : digit - bcd_t'(1);
        end
    end

    assign is_zero    = (digit == '0);
    assign borrow_out = dec_in & is_zero;

endmodule : bcd_down_digit

// File: rtl/sec_tens_min_counter.sv
// Tens-of-seconds / minutes countdown stage: borrow edge detect, three chained
// digits, zero detection and the one-shot expiry strobe.
module sec_tens_min_counter
    import timer_pkg::*;
#(
    parameter int unsigned TSEC_MAX  = TSEC_MAX_C,
    parameter int unsigned MIN_U_MAX = MIN_U_MAX_C,
    parameter int unsigned MIN_T_MAX = MIN_T_MAX_C
) (
    input logic                   clk,
    input logic                   rst_n,
    sec_tens_min_counter_if.slave bus
);

    logic borrow_q;
    logic dec_c;
    logic stage_zero;
    logic stage_zero_d;
    logic reach_zero_q;
    logic expired_q;

    bcd_t tsec_v, min_u_v, min_t_v;
    logic tsec_borrow, min_u_borrow, sat_c;
    logic tsec_zero, min_u_zero, min_t_zero;

    // Reset high so a borrow already asserted at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) borrow_q <= 1'b1;
        else        borrow_q <= bus.borrow_in;
    end

    assign dec_c = bus.borrow_in & ~borrow_q & ~bus.pause & ~bus.load;

    bcd_down_digit #(.MAX(TSEC_MAX)) u_tsec (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (bus.load),
        .load_val   (bus.preset_tsec),
        .dec_in     (dec_c),
        .block      (sat_c),
        .digit      (tsec_v),
        .borrow_out (tsec_borrow),
        .is_zero    (tsec_zero)
    );

    bcd_down_digit #(.MAX(MIN_U_MAX)) u_min_u (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (bus.load),
        .load_val   (bus.preset_min_u),
        .dec_in     (tsec_borrow),
        .block      (sat_c),
        .digit      (min_u_v),
        .borrow_out (min_u_borrow),
        .is_zero    (min_u_zero)
    );

    // A borrow falling out of the top digit means every digit is already zero.
    bcd_down_digit #(.MAX(MIN_T_MAX)) u_min_t (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (bus.load),
        .load_val   (bus.preset_min_t),
        .dec_in     (min_u_borrow),
        .block      (sat_c),
        .digit      (min_t_v),
        .borrow_out (sat_c),
        .is_zero    (min_t_zero)
    );

    // Next value of the all-zero flag, tracking the digits edge for edge.
    always_comb begin
        stage_zero_d = tsec_zero & min_u_zero & min_t_zero;
        if (bus.load) begin
            stage_zero_d = (bus.preset_tsec  == '0) &&
                           (bus.preset_min_u == '0) &&
                           (bus.preset_min_t == '0);
        end else if (dec_c && !sat_c) begin
            stage_zero_d = (tsec_v == bcd_t'(1)) & min_u_zero & min_t_zero;
        end
    end

    // reach_zero_q resets high so reset alone never produces an expiry strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_zero   <= 1'b1;
            reach_zero_q <= 1'b1;
            expired_q    <= 1'b0;
        end else begin
            stage_zero   <= stage_zero_d;
            reach_zero_q <= bus.reach_zero;
            expired_q    <= bus.reach_zero & ~reach_zero_q;
        end
    end

    assign bus.reach_zero = stage_zero & bus.units_zero;
    assign bus.expired    = expired_q;
    assign bus.tsec       = tsec_v;
    assign bus.min_u      = min_u_v;
    assign bus.min_t      = min_t_v;

endmodule : sec_tens_min_counter

// File: tb/tb_sec_tens_min_counter.sv
// Bench for sec_tens_min_counter: vector table plus hand sequences, checked
// through an expected-output queue popped after each clock edge.
module tb_sec_tens_min_counter;
    import timer_pkg::*;

    logic clk;
    logic rst_n;

    sec_tens_min_counter_if bus ();

    sec_tens_min_counter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic b, uz, p, ld;
        bcd_t pt, pu, pm;
        bcd_t e_tsec, e_min_u, e_min_t;
        logic e_rz, e_exp;
    } vec_t;

    typedef struct {
        bcd_t tsec, min_u, min_t;
        logic rz, ex;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   checks;
    int   errors;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, " queue_empty"}, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, " tsec"},       int'(bus.tsec),       int'(e.tsec));
        chk({tag, " min_u"},      int'(bus.min_u),      int'(e.min_u));
        chk({tag, " min_t"},      int'(bus.min_t),      int'(e.min_t));
        chk({tag, " reach_zero"}, int'(bus.reach_zero), int'(e.rz));
        chk({tag, " expired"},    int'(bus.expired),    int'(e.ex));
    endtask

    // Apply inputs, queue what must appear after the next edge, then check.
    task automatic step(input logic b, input logic uz, input logic p, input logic ld,
                        input bcd_t pt, input bcd_t pu, input bcd_t pm,
                        input bcd_t et, input bcd_t eu, input bcd_t em,
                        input logic erz, input logic eex, input string tag);
        exp_t e;
        bus.borrow_in    = b;
        bus.units_zero   = uz;
        bus.pause        = p;
        bus.load         = ld;
        bus.preset_tsec  = pt;
        bus.preset_min_u = pu;
        bus.preset_min_t = pm;
        e.tsec = et; e.min_u = eu; e.min_t = em; e.rz = erz; e.ex = eex;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    function automatic vec_t mk(input logic b, input logic uz, input logic p, input logic ld,
                                input int pt, input int pu, input int pm,
                                input int et, input int eu, input int em,
                                input logic erz, input logic eex);
        vec_t v;
        v.b = b; v.uz = uz; v.p = p; v.ld = ld;
        v.pt = bcd_t'(pt); v.pu = bcd_t'(pu); v.pm = bcd_t'(pm);
        v.e_tsec = bcd_t'(et); v.e_min_u = bcd_t'(eu); v.e_min_t = bcd_t'(em);
        v.e_rz = erz; v.e_exp = eex;
        return v;
    endfunction

    initial begin
        bcd_t exp_ts;
        checks = 0;
        errors = 0;

        //          b  uz p  ld  pt pu pm   ts mu mt rz ex
        vecs.push_back(mk(0, 0, 0, 1,  5, 9, 5,  5, 9, 5, 0, 0)); // load 5/9/5
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0,  4, 9, 5, 0, 0)); // borrow edge
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0,  4, 9, 5, 0, 0)); // held level
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,  4, 9, 5, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0, 1,  0, 0, 1, 0, 0)); // load 0/0/1
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0,  5, 9, 0, 0, 0)); // full ripple
        vecs.push_back(mk(0, 1, 0, 1,  1, 0, 0,  1, 0, 0, 0, 0)); // load 1/0/0
        vecs.push_back(mk(1, 1, 0, 0,  0, 0, 0,  0, 0, 0, 1, 0)); // reach zero
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0,  0, 0, 0, 1, 1)); // expired
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0,  0, 0, 0, 1, 0)); // one cycle only
        vecs.push_back(mk(1, 1, 0, 0,  0, 0, 0,  0, 0, 0, 1, 0)); // saturate
        vecs.push_back(mk(0, 0, 0, 1,  2, 3, 4,  2, 3, 4, 0, 0)); // load 2/3/4
        vecs.push_back(mk(1, 0, 1, 0,  0, 0, 0,  2, 3, 4, 0, 0)); // edge in pause
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0,  2, 3, 4, 0, 0)); // not replayed
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,  2, 3, 4, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1,  5, 5, 5,  5, 5, 5, 0, 0)); // load beats edge
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0,  5, 5, 5, 0, 0)); // edge consumed
        vecs.push_back(mk(0, 0, 0, 1, 12,15, 7,  5, 9, 5, 0, 0)); // clamp
        vecs.push_back(mk(0, 1, 0, 1,  0, 0, 0,  0, 0, 0, 1, 0)); // load zeros
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0,  0, 0, 0, 1, 1)); // expired
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0,  0, 0, 0, 1, 1)); // units_zero rise
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0,  0, 0, 0, 1, 0));

        // Reset with borrow held high
        rst_n = 1'b0;
        bus.borrow_in = 1'b1; bus.units_zero = 1'b1; bus.pause = 1'b0; bus.load = 1'b0;
        bus.preset_tsec = '0; bus.preset_min_u = '0; bus.preset_min_t = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset tsec",       int'(bus.tsec), 0);
        chk("reset expired",    int'(bus.expired), 0);
        chk("reset reach_zero", int'(bus.reach_zero), 1);
        rst_n = 1'b1;
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "post_reset0");
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "post_reset1");

        foreach (vecs[i]) begin
            step(vecs[i].b, vecs[i].uz, vecs[i].p, vecs[i].ld,
                 vecs[i].pt, vecs[i].pu, vecs[i].pm,
                 vecs[i].e_tsec, vecs[i].e_min_u, vecs[i].e_min_t,
                 vecs[i].e_rz, vecs[i].e_exp, $sformatf("vec%0d", i));
        end

        // Three 4-cycle borrow pulses: exactly three decrements
        step(0, 0, 0, 1, 5, 9, 5, 5, 9, 5, 0, 0, "pulse_load");
        exp_ts = bcd_t'(5);
        for (int p = 0; p < 3; p++) begin
            exp_ts = exp_ts - bcd_t'(1);
            for (int c = 0; c < 4; c++)
                step(1, 0, 0, 0, 0, 0, 0, exp_ts, 9, 5, 0, 0, $sformatf("pulse%0d_hi%0d", p, c));
            step(0, 0, 0, 0, 0, 0, 0, exp_ts, 9, 5, 0, 0, $sformatf("pulse%0d_lo", p));
        end

        // Asynchronous reset mid-count, away from any clock edge
        step(1, 1, 0, 0, 0, 0, 0, 1, 9, 5, 0, 0, "pre_async");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async tsec",  int'(bus.tsec), 0);
        chk("async min_u", int'(bus.min_u), 0);
        chk("async min_t", int'(bus.min_t), 0);
        chk("async expired", int'(bus.expired), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "after_async0");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "after_async1");

        chk("queue drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sec_tens_min_counter
